// File: rtl/tune_ctrl.sv
// tune_ctrl: station tuning controller for the FM receiver.
// Holds the tuned frequency (units of 100 kHz), takes up/down/preset
// requests, and computes the DDS phase reload constant
// K = (freq*STEP_K)>>8 with an 11-step shift-add multiplier. In the same
// 11 steps it converts freq to four BCD digits with a double-dabble shifter.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   up, down         1-cycle step requests (+/-100 kHz, wrap at the band edges)
//   preset           1-cycle request to load preset_freq (clamped to the band)
//   preset_freq[10:0] preset target, binary, units of 100 kHz
//   K                registered DDS reload constant
//   k_valid          1-cycle pulse when K/freq_bcd were just updated
//   busy             high while a computation is running
//   freq_bcd[15:0]   frequency as 4 BCD digits, e.g. 16'h0877 = 87.7 MHz
module tune_ctrl #(
  parameter int          WIDTH_DDS = 32,
  parameter int          F_MIN     = 875,
  parameter int          F_MAX     = 1080,
  parameter int          F_RESET   = 1000,
  parameter int unsigned STEP_K    = 458129845
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 up,
  input  logic                 down,
  input  logic                 preset,
  input  logic [10:0]          preset_freq,
  output logic [WIDTH_DDS-1:0] K,
  output logic                 k_valid,
  output logic                 busy,
  output logic [15:0]          freq_bcd
);

  // Accumulator holds freq*STEP_K exactly: 8 fractional bits plus one guard bit.
  localparam int AW = WIDTH_DDS + 9;
  localparam logic [AW-1:0] STEP_A = AW'(STEP_K);

  function automatic logic [15:0] bin2bcd(input logic [10:0] b);
    logic [15:0] s;
    s = '0;
    for (int i = 10; i >= 0; i--) begin
      for (int d = 0; d < 4; d++)
        if (s[4*d +: 4] >= 4'd5) s[4*d +: 4] = s[4*d +: 4] + 4'd3;
      s = {s[14:0], b[i]};
    end
    return s;
  endfunction

  localparam logic [63:0]          RST_PROD = 64'(F_RESET) * 64'(STEP_K);
  localparam logic [WIDTH_DDS-1:0] RST_K    = RST_PROD[WIDTH_DDS+7:8];
  localparam logic [15:0]          RST_BCD  = bin2bcd(11'(F_RESET));

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [1:0] {P_NONE, P_UP, P_DN, P_PRE} pend_t;

  state_t                 state_q;
  pend_t                  pend_q;
  logic [10:0]            pend_freq_q;
  logic [10:0]            freq_q;
  logic [10:0]            fsh_q;      // freq copy shifted out MSB first
  logic [AW-1:0]          acc_q;
  logic [15:0]            bcd_q;
  logic [3:0]             cnt_q;
  logic [WIDTH_DDS-1:0]   k_q;
  logic [15:0]            freq_bcd_q;
  logic                   k_valid_q;

  logic [10:0] clamp_d, up_d, dn_d, freq_d;
  logic        step_up, step_dn, new_req, accept_d;
  logic [15:0] bcd_adj;

  assign step_up = up & ~down & ~preset;
  assign step_dn = down & ~up & ~preset;
  assign new_req = preset | step_up | step_dn;

  always_comb begin
    clamp_d = preset_freq;
    if (preset_freq < 11'(F_MIN)) clamp_d = 11'(F_MIN);
    else if (preset_freq > 11'(F_MAX)) clamp_d = 11'(F_MAX);
    up_d = (freq_q == 11'(F_MAX)) ? 11'(F_MIN) : freq_q + 11'd1;
    dn_d = (freq_q == 11'(F_MIN)) ? 11'(F_MAX) : freq_q - 11'd1;
  end

  // A fresh request in IDLE supersedes an older pending one.
  always_comb begin
    freq_d   = freq_q;
    accept_d = new_req || (pend_q != P_NONE);
    if (preset)       freq_d = clamp_d;
    else if (step_up) freq_d = up_d;
    else if (step_dn) freq_d = dn_d;
    else begin
      case (pend_q)
        P_UP:    freq_d = up_d;
        P_DN:    freq_d = dn_d;
        P_PRE:   freq_d = pend_freq_q;
        default: freq_d = freq_q;
      endcase
    end
  end

  // Double-dabble correction: digits >= 5 get +3 before the shift.
  for (genvar gi = 0; gi < 4; gi++) begin : g_dabble
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= P_NONE;
      pend_freq_q <= '0;
      freq_q      <= 11'(F_RESET);
      fsh_q       <= '0;
      acc_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      k_q         <= RST_K;
      freq_bcd_q  <= RST_BCD;
      k_valid_q   <= 1'b0;
    end else begin
      k_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            freq_q  <= freq_d;
            fsh_q   <= freq_d;
            acc_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= P_NONE;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= {acc_q[AW-2:0], 1'b0} + (fsh_q[10] ? STEP_A : '0);
          bcd_q <= {bcd_adj[14:0], fsh_q[10]};
          fsh_q <= {fsh_q[9:0], 1'b0};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd10) state_q <= DONE;
        end
        DONE: begin
          k_q        <= acc_q[WIDTH_DDS+7:8];
          freq_bcd_q <= bcd_q;
          k_valid_q  <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Requests arriving mid-computation are parked; last one wins.
      if (state_q != IDLE) begin
        if (preset) begin
          pend_q      <= P_PRE;
          pend_freq_q <= clamp_d;
        end else if (step_up) begin
          pend_q <= P_UP;
        end else if (step_dn) begin
          pend_q <= P_DN;
        end
      end
    end
  end

  assign K        = k_q;
  assign freq_bcd = freq_bcd_q;
  assign k_valid  = k_valid_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_tune_ctrl.sv
module tb_tune_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        up = 1'b0, down = 1'b0, preset = 1'b0;
  logic [10:0] preset_freq = '0;
  logic [31:0] K;
  logic        k_valid, busy;
  logic [15:0] freq_bcd;

  int vec = 0;
  int miss = 0;

  tune_ctrl dut (
    .clk(clk), .reset(reset), .up(up), .down(down), .preset(preset),
    .preset_freq(preset_freq), .K(K), .k_valid(k_valid), .busy(busy),
    .freq_bcd(freq_bcd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one request pulse across a single active edge.
  task automatic pulse(input logic u, input logic d, input logic p, input logic [10:0] pf);
    up = u; down = d; preset = p; preset_freq = pf;
    tick();
    up = 1'b0; down = 1'b0; preset = 1'b0;
  endtask

  // Count edges until k_valid is seen; -1 if the budget runs out.
  task automatic wait_kv(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (k_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic no_kv(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (k_valid || busy) seen = 1'b1;
    end
    chk(tag, {31'd0, seen}, 32'd0);
  endtask

  task automatic req_check(input string tag, input logic u, input logic d, input logic p,
                           input logic [10:0] pf, input logic [31:0] ek, input logic [15:0] eb);
    int n;
    pulse(u, d, p, pf);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_kv(n);
    chk({tag, "_lat"}, n, 32'd12);
    chk({tag, "_K"}, K, ek);
    chk({tag, "_bcd"}, {16'd0, freq_bcd}, {16'd0, eb});
    tick();
    chk({tag, "_kv_once"}, {31'd0, k_valid}, 32'd0);
    $display("req %s: K=%0d bcd=%h latency=%0d", tag, K, freq_bcd, n);
  endtask

  initial begin
    int n;
    // 1: reset held 3 cycles
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_K", K, 32'd1789569707);
    chk("rst_bcd", {16'd0, freq_bcd}, 32'h1000);
    chk("rst_kv", {31'd0, k_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    $display("reset: K=%0d bcd=%h", K, freq_bcd);

    // 2: preset 877, plus check K holds during CALC
    pulse(1'b0, 1'b0, 1'b1, 11'd877);
    repeat (5) tick();
    chk("calc_hold_K", K, 32'd1789569707);
    chk("calc_hold_bcd", {16'd0, freq_bcd}, 32'h1000);
    wait_kv(n);
    chk("p877_lat", n, 32'd7);
    chk("p877_K", K, 32'd1569452633);
    chk("p877_bcd", {16'd0, freq_bcd}, 32'h0877);
    tick();
    $display("req p877: K=%0d bcd=%h", K, freq_bcd);

    // 4: clamp high and low
    req_check("p1200", 1'b0, 1'b0, 1'b1, 11'd1200, 32'd1932735283, 16'h1080);
    req_check("p100",  1'b0, 1'b0, 1'b1, 11'd100,  32'd1565873493, 16'h0875);
    // 3: preset 1080, up wraps to 875, down wraps back to 1080
    req_check("p1080", 1'b0, 1'b0, 1'b1, 11'd1080, 32'd1932735283, 16'h1080);
    req_check("up_wrap", 1'b1, 1'b0, 1'b0, 11'd0, 32'd1565873493, 16'h0875);
    req_check("dn_wrap", 1'b0, 1'b1, 1'b0, 11'd0, 32'd1932735283, 16'h1080);
    req_check("dn_1079", 1'b0, 1'b1, 1'b0, 11'd0, 32'd1930945713, 16'h1079);

    // 5: requests while busy; the later down overwrites the earlier up
    reset = 1'b1; tick(); reset = 1'b0; tick();
    pulse(1'b1, 1'b0, 1'b0, 11'd0);      // E0
    tick(); tick();                       // E1, E2
    pulse(1'b1, 1'b0, 1'b0, 11'd0);      // E3
    tick();                               // E4
    pulse(1'b0, 1'b1, 1'b0, 11'd0);      // E5
    wait_kv(n);
    chk("pend1_lat", n, 32'd7);
    chk("pend1_K", K, 32'd1791359276);
    chk("pend1_bcd", {16'd0, freq_bcd}, 32'h1001);
    $display("req pend1: K=%0d bcd=%h", K, freq_bcd);
    wait_kv(n);
    chk("pend2_spacing", n, 32'd13);
    chk("pend2_K", K, 32'd1789569707);
    chk("pend2_bcd", {16'd0, freq_bcd}, 32'h1000);
    $display("req pend2: K=%0d bcd=%h", K, freq_bcd);
    no_kv("pend_no_third", 20);

    // 6: up+down together in IDLE is dropped
    pulse(1'b1, 1'b1, 1'b0, 11'd0);
    no_kv("updn_drop", 15);
    chk("updn_bcd", {16'd0, freq_bcd}, 32'h1000);
    $display("req updn: dropped, bcd=%h", freq_bcd);

    // preset wins over a simultaneous up
    req_check("pre_beats_up", 1'b1, 1'b0, 1'b1, 11'd877, 32'd1569452633, 16'h0877);

    // 7: reset during CALC aborts the computation
    pulse(1'b0, 1'b0, 1'b1, 11'd1080);
    repeat (4) tick();
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    chk("abort_K", K, 32'd1789569707);
    chk("abort_bcd", {16'd0, freq_bcd}, 32'h1000);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_kv", {31'd0, k_valid}, 32'd0);
    reset = 1'b0;
    no_kv("abort_no_kv", 15);
    $display("req abort: K=%0d bcd=%h", K, freq_bcd);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
